// File: rtl/fftl_seq_ctrl.sv
// Fine frequency tracking loop sequencer and supervisor (ref_clk domain).
// Powers the aux oscillator, waits for it to settle, enables tracking with a
// coarse step, gear-shifts step/averaging down as the fine code dithers,
// declares lock and flags saturation/timeout failures.
// Ports:
//   ref_clk, rst (sync, active-high), seq_en (level enable)
//   commit_in, fine_code_in[7:0]      : async inputs from the tracking loop
//   aux_osc_en, fftl_en               : oscillator / loop enables
//   fine_con_step_size[3:0]           : current step size
//   fine_control_avg_window_select[4:0]: current averaging window
//   locked, fail, fail_cause[1:0] (0 none, 1 saturation, 2 timeout)
//   seq_state[2:0]                    : IDLE=0 SETTLE=1 TRACK=2 LOCKED=3 FAIL=4
module fftl_seq_ctrl #(
  parameter int unsigned SETTLE_CYCLES  = 1024,
  parameter int unsigned START_STEP     = 8,
  parameter int unsigned MIN_STEP       = 1,
  parameter int unsigned REV_PER_GEAR   = 4,
  parameter int unsigned LOCK_WIN       = 2,
  parameter int unsigned LOCK_COUNT     = 8,
  parameter int unsigned UNLOCK_WIN     = 6,
  parameter int unsigned AVG_WIN_COARSE = 4,
  parameter int unsigned AVG_WIN_FINE   = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1 << 20
) (
  input  logic       ref_clk,
  input  logic       rst,
  input  logic       seq_en,
  input  logic       commit_in,
  input  logic [7:0] fine_code_in,
  output logic       aux_osc_en,
  output logic       fftl_en,
  output logic [3:0] fine_con_step_size,
  output logic [4:0] fine_control_avg_window_select,
  output logic       locked,
  output logic       fail,
  output logic [1:0] fail_cause,
  output logic [2:0] seq_state
);

  localparam int unsigned SW  = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned RW  = $clog2(REV_PER_GEAR + 1);
  localparam int unsigned LW  = $clog2(LOCK_COUNT + 1);
  localparam logic [3:0] START_S = 4'(START_STEP);
  localparam logic [3:0] MIN_S   = 4'(MIN_STEP);
  localparam logic [4:0] AVG_C   = 5'(AVG_WIN_COARSE);
  localparam logic [4:0] AVG_F   = 5'(AVG_WIN_FINE);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_TRACK  = 3'd2,
    S_LOCKED = 3'd3,
    S_FAIL   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DOWN = 2'd2
  } dir_t;

  // Input synchronizers and commit-edge delay
  logic       commit_s1, commit_s2, commit_d;
  logic [7:0] code_s1, code_s2;
  logic       pend_q;
  logic [1:0] dcnt_q;
  logic       commit_edge, upd;

  assign commit_edge = commit_s2 & ~commit_d;
  // A fresh edge on the firing cycle restarts the delay instead of firing.
  assign upd = pend_q && (dcnt_q == 2'd2) && !commit_edge;

  always_ff @(posedge ref_clk) begin
    if (rst) begin
      commit_s1 <= 1'b0;
      commit_s2 <= 1'b0;
      commit_d  <= 1'b0;
      code_s1   <= '0;
      code_s2   <= '0;
      pend_q    <= 1'b0;
      dcnt_q    <= '0;
    end else begin
      commit_s1 <= commit_in;
      commit_s2 <= commit_s1;
      commit_d  <= commit_s2;
      code_s1   <= fine_code_in;
      code_s2   <= code_s1;
      if (commit_edge) begin
        pend_q <= 1'b1;
        dcnt_q <= '0;
      end else if (pend_q) begin
        if (dcnt_q == 2'd2) pend_q <= 1'b0;
        else                dcnt_q <= dcnt_q + 2'd1;
      end
    end
  end

  // Sequencer state
  state_t      state_q, state_d;
  logic [SW-1:0] scnt_q, scnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [3:0]  step_q, step_d;
  logic [4:0]  avg_q, avg_d;
  logic [7:0]  prev_q, prev_d;
  logic [7:0]  anchor_q, anchor_d;
  dir_t        dir_q, dir_d;
  logic [RW-1:0] rev_q, rev_d;
  logic [LW-1:0] lock_q, lock_d;
  logic [1:0]  cause_q, cause_d;

  always_ff @(posedge ref_clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      scnt_q   <= '0;
      tcnt_q   <= '0;
      step_q   <= START_S;
      avg_q    <= AVG_C;
      prev_q   <= '0;
      anchor_q <= '0;
      dir_q    <= DIR_NONE;
      rev_q    <= '0;
      lock_q   <= '0;
      cause_q  <= '0;
    end else begin
      state_q  <= state_d;
      scnt_q   <= scnt_d;
      tcnt_q   <= tcnt_d;
      step_q   <= step_d;
      avg_q    <= avg_d;
      prev_q   <= prev_d;
      anchor_q <= anchor_d;
      dir_q    <= dir_d;
      rev_q    <= rev_d;
      lock_q   <= lock_d;
      cause_q  <= cause_d;
    end
  end

  // Per-update derived quantities (code_new is the synced code at the event)
  dir_t        dir_new;
  logic        reversal, saturated;
  logic [3:0]  half_step;
  logic signed [8:0] diff;
  logic [8:0]  mag;

  always_comb begin
    dir_new = DIR_NONE;
    if (code_s2 > prev_q)      dir_new = DIR_UP;
    else if (code_s2 < prev_q) dir_new = DIR_DOWN;
    reversal  = (dir_new == DIR_UP && dir_q == DIR_DOWN) ||
                (dir_new == DIR_DOWN && dir_q == DIR_UP);
    saturated = (code_s2 == 8'd0) || (code_s2 == 8'd255);
    half_step = ((step_q >> 1) < MIN_S) ? MIN_S : (step_q >> 1);
    diff      = $signed({1'b0, code_s2}) - $signed({1'b0, anchor_q});
    mag       = diff[8] ? $unsigned(-diff) : $unsigned(diff);
  end

  always_comb begin
    state_d  = state_q;
    scnt_d   = scnt_q;
    tcnt_d   = tcnt_q;
    step_d   = step_q;
    avg_d    = avg_q;
    prev_d   = prev_q;
    anchor_d = anchor_q;
    dir_d    = dir_q;
    rev_d    = rev_q;
    lock_d   = lock_q;
    cause_d  = cause_q;

    case (state_q)
      S_IDLE: begin
        if (seq_en) begin
          state_d = S_SETTLE;
          scnt_d  = '0;
        end
      end
      S_SETTLE: begin
        if (scnt_q == SW'(SETTLE_CYCLES - 1)) begin
          state_d = S_TRACK;
          step_d  = START_S;
          avg_d   = AVG_C;
          prev_d  = code_s2;
          dir_d   = DIR_NONE;
          rev_d   = '0;
          lock_d  = '0;
          tcnt_d  = '0;
        end else begin
          scnt_d = scnt_q + SW'(1);
        end
      end
      S_TRACK: begin
        if (upd && saturated) begin
          state_d = S_FAIL;
          cause_d = 2'd1;
        end else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_FAIL;
          cause_d = 2'd2;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
          if (upd) begin
            prev_d = code_s2;
            if (dir_new != DIR_NONE) dir_d = dir_new;
            // Lock qualification uses the step in force before this update,
            // so the update that enters MIN_STEP only seeds the anchor.
            if (step_q == MIN_S) begin
              if (mag <= 9'(LOCK_WIN)) begin
                lock_d = lock_q + LW'(1);
                if (lock_q == LW'(LOCK_COUNT - 1)) state_d = S_LOCKED;
              end else begin
                anchor_d = code_s2;
                lock_d   = '0;
              end
            end else if (reversal) begin
              if (rev_q == RW'(REV_PER_GEAR - 1)) begin
                step_d = half_step;
                rev_d  = '0;
                if (half_step == MIN_S) begin
                  avg_d    = AVG_F;
                  anchor_d = code_s2;
                  lock_d   = '0;
                end
              end else begin
                rev_d = rev_q + RW'(1);
              end
            end
          end
        end
      end
      S_LOCKED: begin
        if (upd) begin
          prev_d = code_s2;
          if (saturated) begin
            state_d = S_FAIL;
            cause_d = 2'd1;
          end else if (mag > 9'(UNLOCK_WIN)) begin
            state_d = S_TRACK;
            step_d  = START_S;
            avg_d   = AVG_C;
            rev_d   = '0;
            lock_d  = '0;
            dir_d   = DIR_NONE;
            tcnt_d  = '0;
          end
        end
      end
      S_FAIL: ;
      default: state_d = S_IDLE;
    endcase

    if (!seq_en) begin
      state_d = S_IDLE;
      cause_d = '0;
      step_d  = START_S;
      avg_d   = AVG_C;
    end
  end

  assign aux_osc_en = (state_q == S_SETTLE) || (state_q == S_TRACK) ||
                      (state_q == S_LOCKED);
  assign fftl_en    = (state_q == S_TRACK) || (state_q == S_LOCKED);
  assign locked     = (state_q == S_LOCKED);
  assign fail       = (state_q == S_FAIL);
  assign fail_cause = cause_q;
  assign seq_state  = state_q;
  assign fine_con_step_size             = step_q;
  assign fine_control_avg_window_select = avg_q;

endmodule

// File: tb/tb_fftl_seq_ctrl.sv
// Directed self-checking bench for fftl_seq_ctrl.
// dut_a: SETTLE=16, TIMEOUT=64 (power-up, timeout); dut_b: SETTLE=16,
// TIMEOUT=4096 (gear shift, lock, unlock, saturation). Both share stimulus.
module tb_fftl_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst, seq_en, commit;
  logic [7:0] code;

  logic       a_aux, a_fftl, a_locked, a_fail;
  logic [3:0] a_step;
  logic [4:0] a_avg;
  logic [1:0] a_cause;
  logic [2:0] a_state;
  logic       b_aux, b_fftl, b_locked, b_fail;
  logic [3:0] b_step;
  logic [4:0] b_avg;
  logic [1:0] b_cause;
  logic [2:0] b_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fftl_seq_ctrl #(.SETTLE_CYCLES(16), .TIMEOUT_CYCLES(64)) dut_a (
    .ref_clk(clk), .rst(rst), .seq_en(seq_en), .commit_in(commit),
    .fine_code_in(code), .aux_osc_en(a_aux), .fftl_en(a_fftl),
    .fine_con_step_size(a_step), .fine_control_avg_window_select(a_avg),
    .locked(a_locked), .fail(a_fail), .fail_cause(a_cause),
    .seq_state(a_state)
  );

  fftl_seq_ctrl #(.SETTLE_CYCLES(16), .TIMEOUT_CYCLES(4096)) dut_b (
    .ref_clk(clk), .rst(rst), .seq_en(seq_en), .commit_in(commit),
    .fine_code_in(code), .aux_osc_en(b_aux), .fftl_en(b_fftl),
    .fine_con_step_size(b_step), .fine_control_avg_window_select(b_avg),
    .locked(b_locked), .fail(b_fail), .fail_cause(b_cause),
    .seq_state(b_state)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One commit event: code stable first, then a commit pulse. The update is
  // applied on the 6th edge after commit rises (2 sync + detect + 2 delay + 1).
  task automatic update(input logic [7:0] val);
    code = val;
    tick(2);
    commit = 1'b1;
    tick(6);
    commit = 1'b0;
    tick(3);
  endtask

  initial begin
    logic [3:0] exp_step;
    logic [7:0] lock_codes [8];
    lock_codes = '{8'd128, 8'd129, 8'd127, 8'd128,
                   8'd128, 8'd129, 8'd127, 8'd128};

    rst = 1'b1; seq_en = 1'b0; commit = 1'b0; code = 8'd136;
    tick(3);
    check("rst_state", a_state, 0);
    check("rst_aux",   a_aux,   0);
    check("rst_fftl",  a_fftl,  0);
    check("rst_step",  a_step,  8);
    check("rst_avg",   a_avg,   4);
    check("rst_fail",  {a_fail, a_cause, a_locked}, 0);
    rst = 1'b0;
    tick(1);

    // Power-up
    seq_en = 1'b1;
    tick(1);
    check("pu_aux",    a_aux,   1);
    check("pu_settle", a_state, 1);
    check("pu_fftl0",  a_fftl,  0);
    tick(15);
    check("pu_fftl_early", a_fftl, 0);
    tick(1);
    check("pu_fftl",   a_fftl,  1);
    check("pu_track",  a_state, 2);
    check("pu_step",   a_step,  8);
    check("pu_avg",    a_avg,   4);

    // Timeout on dut_a: 64 cycles after TRACK entry with no commits
    tick(63);
    check("to_early",  a_state, 2);
    tick(1);
    check("to_state",  a_state, 4);
    check("to_fail",   a_fail,  1);
    check("to_cause",  a_cause, 2);
    check("to_enables", {a_aux, a_fftl}, 0);
    check("b_no_to",   b_state, 2);

    // Gear shift on dut_b: code_prev=136, codes alternate 128/136
    for (int i = 1; i <= 13; i++) begin
      update((i % 2 == 1) ? 8'd128 : 8'd136);
      exp_step = (i < 5) ? 4'd8 : (i < 9) ? 4'd4 : (i < 13) ? 4'd2 : 4'd1;
      check($sformatf("gear_step_%0d", i), b_step, exp_step);
    end
    check("gear_avg_fine", b_avg, 8);
    check("gear_state",    b_state, 2);

    // Lock: anchor seeded at 128 by the gear update
    for (int i = 0; i < 8; i++) begin
      update(lock_codes[i]);
      if (i == 6) check("lock_pre", {b_state, b_locked}, {3'd2, 1'b0});
    end
    check("lock_locked", b_locked, 1);
    check("lock_state",  b_state,  3);
    check("lock_hold",   {b_step, b_avg}, {4'd1, 5'd8});

    // Unlock
    update(8'd140);
    check("unlock_locked", b_locked, 0);
    check("unlock_state",  b_state,  2);
    check("unlock_step",   b_step,   8);
    check("unlock_avg",    b_avg,    4);

    // Saturation
    update(8'd255);
    check("sat_state", b_state, 4);
    check("sat_fail",  b_fail,  1);
    check("sat_cause", b_cause, 1);
    check("sat_enables", {b_aux, b_fftl, b_locked}, 0);
    seq_en = 1'b0;
    tick(1);
    check("sat_idle",   b_state, 0);
    check("sat_clear",  {b_fail, b_cause}, 0);
    check("to_clear",   {a_fail, a_cause, a_state}, 0);

    // Reset mid-TRACK
    code = 8'd136;
    seq_en = 1'b1;
    tick(17);
    check("rt_track", b_state, 2);
    rst = 1'b1;
    tick(1);
    check("rt_state", b_state, 0);
    check("rt_en",    {b_aux, b_fftl, b_locked, b_fail}, 0);
    check("rt_step",  {b_step, b_avg}, {4'd8, 5'd4});
    rst = 1'b0;
    seq_en = 1'b0;
    tick(2);

    // seq_en drop mid-SETTLE
    seq_en = 1'b1;
    tick(6);
    check("ab_settle", a_state, 1);
    seq_en = 1'b0;
    tick(1);
    check("ab_idle", a_state, 0);
    check("ab_aux",  a_aux,   0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
